// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit driving a req/gnt/rvalid data-memory port
// Optional response watchdog when LSU_TIMEOUT_EN is defined (limit TIMEOUT_CYCLES).
module load_store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic                    i_write,
  input  logic [1:0]              i_size,
  input  logic                    i_sign_ext,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_misaligned,
  output logic                    o_bus_error,
  output logic                    o_mem_req,
  input  logic                    i_mem_gnt,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic                    o_mem_we,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  input  logic                    i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
  state_t state, state_nxt;

  logic [OFFS-1:0]       off_q;
  logic [1:0]            size_q;
  logic                  sign_q;
  logic                  write_q;
  logic [OFFS-1:0]       in_off;
  logic                  misaligned;
  logic                  accept;
  logic                  timeout;
  logic [7:0]            be_wide;
  logic [BYTES-1:0]      be_base;
  logic [DATA_WIDTH-1:0] lane, keep, ext;
  logic                  sbit;

  assign in_off  = i_addr[OFFS-1:0];
  assign accept  = i_valid && (state == S_IDLE);
  assign be_base = be_wide[BYTES-1:0];
  assign lane    = i_mem_rdata >> {off_q, 3'b000};

  always_comb begin
    misaligned = 1'b0;
    be_wide    = 8'h00;
    case (i_size)
      2'd0: be_wide = 8'h01;
      2'd1: begin be_wide = 8'h03; misaligned = i_addr[0];    end
      2'd2: begin be_wide = 8'h0F; misaligned = |i_addr[1:0]; end
      default: begin
        be_wide    = 8'hFF;
        misaligned = (DATA_WIDTH == 32) || (|i_addr[2:0]);
      end
    endcase
  end

  // Extension by masking: bits above the kept width become copies of the sign bit or zero.
  always_comb begin
    keep = '1;
    sbit = lane[DATA_WIDTH-1];
    case (size_q)
      2'd0: begin keep = ~({DATA_WIDTH{1'b1}} << 8);  sbit = lane[7];  end
      2'd1: begin keep = ~({DATA_WIDTH{1'b1}} << 16); sbit = lane[15]; end
      2'd2: begin keep = ~({DATA_WIDTH{1'b1}} << 32); sbit = lane[31]; end
      default: begin keep = '1; sbit = lane[DATA_WIDTH-1]; end
    endcase
    ext = (lane & keep) | ((sign_q && sbit) ? ~keep : '0);
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_mem_req = 1'b0;
    case (state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nxt = misaligned ? S_RESP : S_REQ;
      end
      S_REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_gnt) state_nxt = S_WAIT;
      end
      S_WAIT: if (i_mem_rvalid || timeout) state_nxt = S_RESP;
      S_RESP: begin
        o_valid   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      off_q        <= '0;
      size_q       <= '0;
      sign_q       <= 1'b0;
      write_q      <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_we     <= 1'b0;
      o_mem_be     <= '0;
      o_mem_wdata  <= '0;
      o_misaligned <= 1'b0;
      o_rdata      <= '0;
    end else if (accept) begin
      off_q        <= in_off;
      size_q       <= i_size;
      sign_q       <= i_sign_ext;
      write_q      <= i_write;
      o_mem_addr   <= {i_addr[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
      o_mem_we     <= i_write;
      o_mem_be     <= be_base << in_off;
      o_mem_wdata  <= i_wdata << {in_off, 3'b000};
      o_misaligned <= misaligned;
      o_rdata      <= '0;
    end else if (state == S_WAIT && i_mem_rvalid) begin
      o_rdata <= write_q ? '0 : ext;
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tcnt;
  logic          bus_err_q;

  assign timeout     = (state == S_WAIT) && !i_mem_rvalid && (tcnt == TLIM);
  assign o_bus_error = bus_err_q;

  // Counter idles at zero outside WAIT, so it is cleared on every entry.
  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) tcnt <= '0;
    else                        tcnt <= tcnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || accept) bus_err_q <= 1'b0;
    else if (timeout)  bus_err_q <= 1'b1;
  end
`else
  assign timeout     = 1'b0;
  assign o_bus_error = 1'b0;
`endif

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Parametrised successor to the pass-through load/store stage. Sits between EX/MEM and the data-memory port.
- Accepts one load/store at a time via valid/ready.
- Generates byte enables and lane-shifted write data, and drives a req/gnt/rvalid memory handshake with variable latency.
- Returns lane-extracted, sign/zero-extended load data and flags misaligned accesses without touching memory.

Parameters:
- DATA_WIDTH, 32, memory/register data width; legal values 32 or 64. BYTES = DATA_WIDTH/8, OFFS = log2(BYTES).
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 256, watchdog limit in WAIT; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_valid  in  1  request valid from EX/MEM
- o_ready  out  1  LSU can accept a request (high only in IDLE)
- i_addr  in  ADDR_WIDTH  byte address
- i_wdata  in  DATA_WIDTH  store data, right-aligned
- i_write  in  1  1 = store, 0 = load
- i_size  in  2  00 byte, 01 half, 10 word, 11 dword (dword legal only when DATA_WIDTH=64)
- i_sign_ext  in  1  sign-extend load result
- o_valid  out  1  one-cycle completion pulse
- o_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- o_misaligned  out  1  completion was a misaligned or illegal-size access
- o_bus_error  out  1  completion was a timeout (feature only; otherwise tied 0)
- o_mem_req  out  1  memory request
- i_mem_gnt  in  1  memory accepted the request
- o_mem_addr  out  ADDR_WIDTH  word-aligned address (low OFFS bits zero)
- o_mem_we  out  1  write enable
- o_mem_be  out  BYTES  byte enables
- o_mem_wdata  out  DATA_WIDTH  lane-shifted store data
- i_mem_rvalid  in  1  response/ack; load data valid on this cycle
- i_mem_rdata  in  DATA_WIDTH  read data, full word

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high.
- Reset values: state IDLE; o_valid, o_mem_req, o_mem_we, o_misaligned, o_bus_error = 0; o_mem_be = 0; o_rdata = 0; o_mem_addr and o_mem_wdata = 0.
- Request capture: on i_valid && o_ready, register addr, wdata, write, size, sign_ext.
- Misalignment check at capture: misaligned = addr[size-1:0] != 0 for size>0; size=11 with DATA_WIDTH=32 is also treated as misaligned.
- States:
  - IDLE: o_ready=1. Accepted aligned request -> REQ. Accepted misaligned request -> RESP with o_misaligned=1 and no memory traffic.
  - REQ: o_mem_req=1, with addr/we/be/wdata stable until i_mem_gnt. gnt -> WAIT. req stays high across gnt-low cycles.
  - WAIT: o_mem_req=0; wait for i_mem_rvalid. rvalid -> RESP; capture extended load data on that same cycle.
  - RESP: o_valid=1 for exactly one cycle -> IDLE. o_ready=0 in RESP.
- Latency: minimum 3 cycles from acceptance to o_valid (gnt in first REQ cycle, rvalid in first WAIT cycle). Misaligned requests complete in 1 cycle.
- Byte enables: o_mem_be = ({size==0: 1, 1: 3, 2: 0xF, 3: 0xFF} truncated to BYTES) << addr[OFFS-1:0].
- Write data: o_mem_wdata = i_wdata << (8*addr[OFFS-1:0]). Bytes outside be are don't-care but driven deterministically by the shift.
- Load data: lane = i_mem_rdata >> (8*offset). Keep low 8/16/32/64 bits, then sign-extend from the top kept bit if i_sign_ext, else zero-extend.
- Stores: o_rdata=0. rvalid is the write ack and rdata is ignored.
- i_mem_rvalid outside WAIT is ignored, including rvalid coincident with gnt in REQ. Memory must respond at least 1 cycle after gnt.
- i_valid while not ready: no capture; the upstream stage holds its request.
- Reset mid-operation: return to IDLE, drop req, discard the pending result; no o_valid.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined: cycle counter cleared on entry to WAIT. If it reaches TIMEOUT_CYCLES without rvalid -> RESP with o_bus_error=1 and o_rdata=0. A late rvalid arriving in IDLE is ignored.
- Undefined: no counter; WAIT waits indefinitely; o_bus_error tied 0.

Test Plan:
- DATA_WIDTH=32, load byte, addr 0x1003, sign_ext=1, rdata 0x80FF_FF11 with gnt and rvalid immediate -> be=1000, mem_addr=0x1000, o_rdata=0xFFFF_FF80, o_valid 3 cycles after accept.
- Store half, addr 0x2002, wdata 0x0000_BEEF, gnt delayed 4 cycles -> req held 5 cycles, be=1100, mem_wdata=0xBEEF_xxxx, we=1, o_valid after ack with o_rdata=0.
- Load word at addr 0x0006 -> o_misaligned=1 next cycle, o_mem_req never asserts, o_rdata=0.
- DATA_WIDTH=64, load word unsigned at addr 0x0C, rdata 0x8765_4321_0000_0000 -> be=0xF0, o_rdata=0x0000_0000_8765_4321.
- Assert rst in WAIT, then send rvalid -> no o_valid; o_ready=1 the cycle after reset; the next request completes normally.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, rvalid never comes -> o_valid with o_bus_error=1 8 cycles after entering WAIT.
